// File: rtl/asteroid_pkg.sv
// rtl/asteroid_pkg.sv - shared states, colours and screen constants for the asteroid blocks
package asteroid_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPAWN  = 3'd1,
      ST_DRAW   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_ERASE  = 3'd4,
      ST_MOVE   = 3'd5,
      ST_ABORT  = 3'd6,
      ST_LANDED = 3'd7
   } state_t;

   localparam logic [2:0] COLOUR_BLACK    = 3'b000;
   localparam logic [2:0] COLOUR_ASTEROID = 3'b111;

   // Screen geometry also used by the collision checker and the rocket block
   localparam int SCREEN_Y_GROUND = 112;
   localparam int SCREEN_X_MAX    = 152;

   // States in which a request to the plot engine is outstanding
   function automatic logic is_plot_state(input state_t s);
      return (s == ST_DRAW) || (s == ST_ERASE) || (s == ST_ABORT);
   endfunction

endpackage

// File: rtl/asteroid_tick_divider.sv
// rtl/asteroid_tick_divider.sv - counts frame ticks and pulses move_due every TICKS_PER_MOVE ticks
module asteroid_tick_divider #(
   parameter int TICKS_PER_MOVE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic clr,
   input  logic frame_tick,
   output logic move_due
);

   localparam int CW = (TICKS_PER_MOVE > 1) ? $clog2(TICKS_PER_MOVE) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   // The final counted tick wraps the counter itself, so no tick is carried over
   assign move_due = en & frame_tick & (cnt_q == CW'(TICKS_PER_MOVE - 1));

   // Next count: clear wins, ticks only count while enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && frame_tick) begin
         cnt_d = move_due ? '0 : cnt_q + CW'(1);
      end
   end

   // Counter register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/asteroid_descent_ctrl.sv
// rtl/asteroid_descent_ctrl.sv - steps one asteroid sprite from spawn row to ground via the plot engine
module asteroid_descent_ctrl
   import asteroid_pkg::*;
#(
   parameter int          X_W            = 8,
   parameter int          Y_W            = 7,
   parameter int          Y_START        = 0,
   parameter int          Y_GROUND       = SCREEN_Y_GROUND,
   parameter int          X_MAX          = SCREEN_X_MAX,
   parameter int          STEP           = 2,
   parameter int          TICKS_PER_MOVE = 4,
   parameter logic [2:0]  COLOUR         = COLOUR_ASTEROID
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [X_W-1:0] spawn_x,
   input  logic           frame_tick,
   input  logic           hit,
   output logic           plot_req,
   output logic [X_W-1:0] plot_x,
   output logic [Y_W-1:0] plot_y,
   output logic [2:0]     plot_colour,
   input  logic           plot_ack,
   output logic           busy,
   output logic           asteroid_move_done
);

   state_t         state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           hit_q, hit_d;
   logic           plot_req_q, plot_req_d;
   logic [X_W-1:0] plot_x_q, plot_x_d;
   logic [Y_W-1:0] plot_y_q, plot_y_d;
   logic [2:0]     colour_q, colour_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic           ack_ok;
   logic           move_due;
   logic [Y_W:0]   y_next;
   logic [X_W-1:0] spawn_clamped;

   // An ack only counts while our request is actually up, so stray acks are ignored
   assign ack_ok        = plot_ack & plot_req_q;
   // One extra bit so the step past the ground row cannot wrap
   assign y_next        = {1'b0, y_q} + (Y_W+1)'(STEP);
   assign spawn_clamped = (spawn_x > X_W'(X_MAX)) ? X_W'(X_MAX) : spawn_x;

   asteroid_tick_divider #(
      .TICKS_PER_MOVE (TICKS_PER_MOVE)
   ) u_tick_divider (
      .clock      (clock),
      .reset      (reset),
      .en         (state_q == ST_WAIT),
      .clr        (state_q == ST_SPAWN),
      .frame_tick (frame_tick),
      .move_due   (move_due)
   );

   // Next state, position and hit latch, plus the registered output values
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      hit_d   = hit_q;
      case (state_q)
         ST_IDLE, ST_LANDED: begin
            if (start) begin
               state_d = ST_SPAWN;
               x_d     = spawn_clamped;
            end
         end
         ST_SPAWN: begin
            y_d     = Y_W'(Y_START);
            hit_d   = hit;
            state_d = ST_DRAW;
         end
         ST_DRAW: begin
            hit_d = hit_q | hit;
            if (ack_ok) begin
               if (hit_q || hit)                 state_d = ST_ABORT;
               else if (y_q == Y_W'(Y_GROUND))   state_d = ST_LANDED;
               else                              state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (hit)           state_d = ST_ABORT;
            else if (move_due) state_d = ST_ERASE;
         end
         ST_ERASE: begin
            hit_d = hit_q | hit;
            if (ack_ok) state_d = ST_MOVE;
         end
         ST_MOVE: begin
            hit_d   = hit_q | hit;
            y_d     = (y_next >= (Y_W+1)'(Y_GROUND)) ? Y_W'(Y_GROUND) : y_next[Y_W-1:0];
            state_d = ST_DRAW;
         end
         ST_ABORT: begin
            if (ack_ok) begin
               state_d = ST_IDLE;
               hit_d   = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The cycle that consumes an ack always drops the request, so DRAW->ABORT shows a gap
      plot_req_d  = is_plot_state(state_d) && !ack_ok;
      plot_x_d    = plot_req_d ? x_d : '0;
      plot_y_d    = plot_req_d ? y_d : '0;
      colour_d    = (plot_req_d && state_d == ST_DRAW) ? COLOUR : COLOUR_BLACK;
      busy_d      = (state_d != ST_IDLE) && (state_d != ST_LANDED);
      done_d      = (state_d == ST_LANDED);
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         x_q        <= '0;
         y_q        <= Y_W'(Y_START);
         hit_q      <= 1'b0;
         plot_req_q <= 1'b0;
         plot_x_q   <= '0;
         plot_y_q   <= '0;
         colour_q   <= COLOUR_BLACK;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hit_q      <= hit_d;
         plot_req_q <= plot_req_d;
         plot_x_q   <= plot_x_d;
         plot_y_q   <= plot_y_d;
         colour_q   <= colour_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign plot_req           = plot_req_q;
   assign plot_x             = plot_x_q;
   assign plot_y             = plot_y_q;
   assign plot_colour        = colour_q;
   assign busy               = busy_q;
   assign asteroid_move_done = done_q;

endmodule

// File: tb/tb_asteroid_descent_ctrl.sv
// tb/tb_asteroid_descent_ctrl.sv - directed bench for asteroid_descent_ctrl
module tb_asteroid_descent_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] spawn_x = '0;
   logic       frame_tick = 1'b0;
   logic       hit = 1'b0;
   logic       plot_ack = 1'b0;
   logic       sel = 1'b0;

   logic       req1, req2, busy1, busy2, done1, done2;
   logic [7:0] x1, x2;
   logic [6:0] y1, y2;
   logic [2:0] c1, c2;

   logic       req_m, busy_m, done_m;
   logic [7:0] x_m;
   logic [6:0] y_m;
   logic [2:0] col_m;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] sx;
      logic [7:0] ex;
   } vec_t;
   vec_t vecs[6];

   always #5 clock = ~clock;

   asteroid_descent_ctrl dut1 (
      .clock (clock), .reset (reset), .start (start & ~sel), .spawn_x (spawn_x),
      .frame_tick (frame_tick & ~sel), .hit (hit & ~sel),
      .plot_req (req1), .plot_x (x1), .plot_y (y1), .plot_colour (c1),
      .plot_ack (plot_ack & ~sel), .busy (busy1), .asteroid_move_done (done1)
   );

   asteroid_descent_ctrl #(.Y_GROUND(5), .TICKS_PER_MOVE(1)) dut2 (
      .clock (clock), .reset (reset), .start (start & sel), .spawn_x (spawn_x),
      .frame_tick (frame_tick & sel), .hit (hit & sel),
      .plot_req (req2), .plot_x (x2), .plot_y (y2), .plot_colour (c2),
      .plot_ack (plot_ack & sel), .busy (busy2), .asteroid_move_done (done2)
   );

   assign req_m  = sel ? req2  : req1;
   assign busy_m = sel ? busy2 : busy1;
   assign done_m = sel ? done2 : done1;
   assign x_m    = sel ? x2    : x1;
   assign y_m    = sel ? y2    : y1;
   assign col_m  = sel ? c2    : c1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic start_pulse(input logic [7:0] sx);
      start = 1'b1;
      spawn_x = sx;
      tick();
      start = 1'b0;
   endtask

   // Wait for a request, check it is held stable for 3 cycles, then ack (optionally with hit)
   task automatic do_plot(input logic [7:0] ex, input logic [6:0] ey, input logic [2:0] ec,
                          input logic with_hit);
      int n = 0;
      while (!req_m && n < 40) begin
         tick();
         n++;
      end
      check("req_seen", {31'b0, req_m}, 1);
      check("plot_x", {24'b0, x_m}, {24'b0, ex});
      check("plot_y", {25'b0, y_m}, {25'b0, ey});
      check("plot_colour", {29'b0, col_m}, {29'b0, ec});
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
      check("plot_hold", {13'b0, req_m, x_m, y_m, col_m}, {13'b0, 1'b1, ex, ey, ec});
      plot_ack = 1'b1;
      hit = with_hit;
      tick();
      plot_ack = 1'b0;
      hit = 1'b0;
      check("req_drop", {31'b0, req_m}, 0);
   endtask

   task automatic run_descent(input logic [7:0] ex, input int gnd, input int ticks, input int stop_y,
                              input bit hit_last, output int draws, output int erases);
      int y = 0;
      draws = 0;
      erases = 0;
      for (int k = 0; k < 200; k++) begin
         if (y == stop_y) begin
            do_plot(ex, 7'(y), 3'b111, hit_last);
            draws++;
            if (hit_last) begin
               check("abort_no_done", {31'b0, done_m}, 0);
               check("abort_busy", {31'b0, busy_m}, 1);
            end else if (y == gnd) begin
               check("land_done", {31'b0, done_m}, 1);
               check("land_busy", {31'b0, busy_m}, 0);
            end else begin
               check("wait_busy", {31'b0, busy_m}, 1);
            end
            break;
         end
         do_plot(ex, 7'(y), 3'b111, 1'b0);
         draws++;
         check("mid_done", {31'b0, done_m}, 0);
         for (int t = 0; t < ticks; t++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            check("tick_to_erase", {31'b0, req_m}, (t == ticks - 1) ? 1 : 0);
            tick();
         end
         do_plot(ex, 7'(y), 3'b000, 1'b0);
         erases++;
         y = (y + 2 >= gnd) ? gnd : y + 2;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int d, e;
      vecs[0] = '{sx: 8'd40,  ex: 8'd40};
      vecs[1] = '{sx: 8'd200, ex: 8'd152};
      vecs[2] = '{sx: 8'd152, ex: 8'd152};
      vecs[3] = '{sx: 8'd153, ex: 8'd152};
      vecs[4] = '{sx: 8'd0,   ex: 8'd0};
      vecs[5] = '{sx: 8'd255, ex: 8'd152};

      // Reset values
      repeat (3) tick();
      check("rst_outputs", {12'b0, req1, x1, y1, c1, busy1, done1}, 0);
      reset = 1'b1;
      tick();

      // Latency and asynchronous reset during DRAW
      start_pulse(8'd40);
      check("spawn_busy", {31'b0, busy1}, 1);
      check("spawn_no_req", {31'b0, req1}, 0);
      tick();
      check("draw_req", {31'b0, req1}, 1);
      #2 reset = 1'b0;
      #1;
      check("async_rst", {29'b0, req1, busy1, done1}, 0);
      tick();
      reset = 1'b1;
      plot_ack = 1'b1;
      tick();
      plot_ack = 1'b0;
      check("late_ack_idle", {30'b0, req1, busy1}, 0);
      tick();
      check("still_idle", {30'b0, req1, busy1}, 0);

      // Full descent to ground
      start_pulse(8'd40);
      run_descent(8'd40, 112, 4, 112, 1'b0, d, e);
      check("draw_count", d, 57);
      check("erase_count", e, 56);
      frame_tick = 1'b1;
      hit = 1'b1;
      tick();
      frame_tick = 1'b0;
      hit = 1'b0;
      repeat (3) tick();
      check("landed_hold", {29'b0, done1, busy1, req1}, 3'b100);

      // Hit during WAIT at y=10, with an ignored start while busy
      start_pulse(8'd40);
      check("respawn_clears_done", {31'b0, done1}, 0);
      run_descent(8'd40, 112, 4, 10, 1'b0, d, e);
      check("draws_to_10", d, 6);
      start_pulse(8'd99);
      check("busy_start_ignored", {30'b0, busy1, req1}, 2'b10);
      hit = 1'b1;
      tick();
      hit = 1'b0;
      check("abort_req", {31'b0, req1}, 1);
      do_plot(8'd40, 7'd10, 3'b000, 1'b0);
      check("abort_idle", {30'b0, busy1, done1}, 0);
      start_pulse(8'd40);
      tick();
      check("restart_y0", {24'b0, req1, y1}, {24'b0, 1'b1, 7'd0});

      // Hit coincident with the landing ack
      run_descent(8'd40, 112, 4, 112, 1'b1, d, e);
      do_plot(8'd40, 7'd112, 3'b000, 1'b0);
      check("coincident_idle", {30'b0, busy1, done1}, 0);

      // Spawn column clamping table
      for (int i = 0; i < 6; i++) begin
         start_pulse(vecs[i].sx);
         do_plot(vecs[i].ex, 7'd0, 3'b111, 1'b1);
         do_plot(vecs[i].ex, 7'd0, 3'b000, 1'b0);
         check("table_idle", {31'b0, busy1}, 0);
      end

      // Saturating step on a short playfield
      sel = 1'b1;
      tick();
      start_pulse(8'd10);
      run_descent(8'd10, 5, 1, 5, 1'b0, d, e);
      check("short_draws", d, 4);
      check("short_erases", e, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/asteroid_descent_ctrl.md
Name: asteroid_descent_ctrl

Overview:
Moves one asteroid from a spawn column at the top of the playfield down toward the ground line, one step per N frame ticks.
- Each step erases the old sprite and draws the new one, using a req/ack handshake with the shared VGA plot engine.
- On touching the ground it raises asteroid_move_done (level). The ground-collision checker samples this signal to decide gameover.
- A rocket hit aborts the descent without asserting done.

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
Y_START, 0, spawn row
Y_GROUND, 112, ground row (asteroid top-left y at landing)
X_MAX, 152, largest legal spawn x (screen width minus sprite width)
STEP, 2, rows moved per move event
TICKS_PER_MOVE, 4, frame ticks per move event (>=1)
COLOUR, 3'b111, asteroid draw colour; erase colour fixed 3'b000

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  1-cycle pulse: begin a new descent
spawn_x  in  X_W  spawn column, sampled on start
frame_tick  in  1  1-cycle pulse per video frame
hit  in  1  1-cycle pulse: asteroid destroyed by rocket
plot_req  out  1  request to plot engine
plot_x  out  X_W  sprite x for request
plot_y  out  Y_W  sprite y for request
plot_colour  out  3  COLOUR or 3'b000
plot_ack  in  1  1-cycle pulse: plot engine finished request
busy  out  1  high in every state except IDLE and LANDED
asteroid_move_done  out  1  level: asteroid has reached ground

Behaviour:
- Reset (async, reset=0): state IDLE. All outputs 0; x=0, y=Y_START; tick counter 0; hit latch 0. A reset during an outstanding plot drops plot_req immediately. A late plot_ack is ignored in IDLE.
- States: IDLE, SPAWN, DRAW, WAIT, ERASE, MOVE, ABORT, LANDED. Transitions below are registered, one cycle each unless waiting.
- IDLE: on start go to SPAWN.
- SPAWN:
  - x = min(spawn_x, X_MAX); y = Y_START.
  - Clear tick counter, hit latch and asteroid_move_done.
  - Go to DRAW.
- DRAW: plot_req=1, colour=COLOUR, plot_x/plot_y = x/y. Hold until plot_ack. On ack, plot_req drops in the same cycle the state changes:
  - hit latch set -> ABORT
  - y == Y_GROUND -> LANDED
  - else -> WAIT
- WAIT: count frame_tick pulses. At the TICKS_PER_MOVE-th pulse, clear the counter and go to ERASE. hit in WAIT -> ABORT.
- ERASE: plot_req=1, colour=3'b000 at the current x/y. On ack go to MOVE.
- MOVE:
  - One cycle.
  - If y + STEP >= Y_GROUND, y = Y_GROUND (saturate; compute with Y_W+1 bits, no wrap). Else y = y + STEP.
  - Then go to DRAW.
- ABORT: plot_req=1, colour=3'b000 at x/y (erase the sprite). On ack go to IDLE; asteroid_move_done stays 0.
- LANDED: asteroid_move_done=1, held until the next start (start -> SPAWN, which clears it). The sprite stays drawn.
- Hit handling:
  - hit is latched in any of SPAWN/DRAW/ERASE/MOVE and acted on at the next decision point.
  - hit in IDLE or LANDED is ignored.
  - hit in the same cycle as the DRAW ack that would land: hit wins (ABORT, no done).
- start while busy is ignored. frame_tick outside WAIT is ignored (no backlog).
- plot_x/plot_y/plot_colour are stable for the whole plot_req assertion. plot_req never pulses for 0 cycles.
- Latency: start -> plot_req high = 2 cycles (SPAWN, then DRAW).

Decomposition:
- Shared package (asteroid_pkg): state encoding localparams, COLOUR_BLACK/COLOUR_ASTEROID, the Y_GROUND/X_MAX screen constants shared with the collision checker and the rocket block.
- One sub-module: asteroid_tick_divider. It counts frame_tick up to TICKS_PER_MOVE, with enable and clear inputs and a move_due pulse output.

Test Plan:
- Reset mid-DRAW (plot_req=1) -> plot_req, busy, done all 0 asynchronously. A later ack is ignored; the FSM stays IDLE.
- start, spawn_x=40, STEP=2, Y_GROUND=112, TICKS=4, ack 3 cycles after each req:
  - draws at y=0,2,...,112, 57 draws and 56 erases in total;
  - done=1 after the final draw ack and held.
- spawn_x=200 -> every plot_x=152.
- Y_GROUND=5, STEP=2 -> y sequence 0,2,4,5 (saturates); done asserts.
- hit during WAIT at y=10 -> one erase at (x,10), then IDLE. done stays 0; a next start respawns at y=0.
- hit coincident with the landing DRAW ack -> ABORT erase, done=0. start while busy -> ignored, no position change.
